irq_pipe_sequencer: RTL and testbench
=====================================

# irq_pipe_sequencer

Interrupt controller that sequences the 5-stage pipeline into and out of an interrupt service routine. It edge-detects and prioritises up to N_IRQ request lines, stalls fetch, drains the ID/EX, EX/MEM and MEM/WB stages so that no forwarding hazard spans the switch, captures the return PC, and redirects fetch to a per-line vector. On `reti_i` it restores the saved PC. It sits beside the fetch stage and the forwarding unit and drives the fetch stall, ID flush and PC-load controls.

## Interface
- N_IRQ, 4, number of interrupt request lines (index 0 = highest priority)
- PC_W, 16, program counter width
- VEC_BASE, 16'h0040, vector base; line k vectors to VEC_BASE + 4*k
- DRAIN_CYC, 3, cycles needed to empty ID/EX, EX/MEM and MEM/WB

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- irq_i  in  N_IRQ  request lines, synchronous to clk, rising-edge sensitive
- mask_we_i  in  1  write strobe for the enable mask
- mask_wdata_i  in  N_IRQ  new mask; 1 = line enabled
- reti_i  in  1  return-from-interrupt decoded in EX
- pc_if_i  in  PC_W  PC of the next instruction to fetch
- stall_if_o  out  1  freeze fetch (branch redirects still update PC)
- flush_id_o  out  1  inject EMPTY opcode into ID/EX
- pc_load_o  out  1  force PC to pc_load_val_o next cycle
- pc_load_val_o  out  PC_W  forced PC value
- epc_o  out  PC_W  saved return PC
- in_isr_o  out  1  ISR active; further interrupts held pending
- irq_id_o  out  $clog2(N_IRQ)  index of the line being serviced

## Operation
- Edge detect: irq_q <= irq_i each cycle. pending[k] is set on irq_i[k] & ~irq_q[k]. It is cleared only in VECTOR for the selected k. If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask register: written on mask_we_i. Reset value is all zeros, so all lines are disabled.
- eligible = pending & mask. The selected line is the lowest set index. Selection evaluates the registered mask; a same-cycle mask write takes effect the next cycle.
- FSM states: IDLE, DRAIN, SAVE, VECTOR, SERVICE, RETURN.
  - IDLE: if eligible != 0, go to DRAIN and latch sel_id.
  - DRAIN: stall_if_o = 1 and flush_id_o = 1 for DRAIN_CYC cycles (down-counter), then go to SAVE. Branches already in EX complete and redirect the PC.
  - SAVE: stall_if_o = 1 and flush_id_o = 1. epc <= pc_if_i. Go to VECTOR.
  - VECTOR: pc_load_o = 1, pc_load_val_o = VEC_BASE + {sel_id, 2'b00}, flush_id_o = 1. Clear pending[sel_id]. irq_id_o <= sel_id. Go to SERVICE.
  - SERVICE: in_isr_o = 1, and no new selection is made. reti_i = 1 goes to RETURN.
  - RETURN: pc_load_o = 1, pc_load_val_o = epc, flush_id_o = 1. Go to IDLE. in_isr_o drops on entry to IDLE.
- reti_i is ignored in every state except SERVICE.
- Vector addition wraps modulo 2^PC_W.
- Edges arriving in any state are recorded in pending. They are serviced in priority order after RETURN.
- Reset asserted at any point forces the state machine to IDLE and clears pending, irq_q, the mask, epc and irq_id. Every output is 0 during and immediately after reset.

## Timing
- All outputs are registered-state decodes (Moore); no combinational path from inputs to outputs.
- An edge on irq_i at cycle t sets pending at t+1, leaves IDLE at t+1, and is in DRAIN for t+2 .. t+1+DRAIN_CYC.
- With DRAIN_CYC = 3: SAVE at t+5, VECTOR at t+6, SERVICE from t+7, first vector fetch at t+7.
- reti_i at cycle r (in SERVICE) gives RETURN at r+1 and IDLE at r+2. A pending eligible line re-enters DRAIN at r+3.
- stall_if_o is high for exactly DRAIN_CYC + 1 cycles per entry. flush_id_o is high for DRAIN_CYC + 2 cycles per entry and 1 cycle per return.

## Test plan
- Basic entry:
  - Stimulus: mask = 4'b1111, pc_if_i = 16'h0100, pulse irq_i[2] at cycle 10.
  - Required: stall_if_o high in cycles 12–15; epc_o = 16'h0100; pc_load_o at cycle 16 with value 16'h0048; in_isr_o high from 17; irq_id_o = 2.
- Priority:
  - Stimulus: raise irq_i[3] and irq_i[1] in the same cycle.
  - Required: line 1 is serviced first (vector 16'h0044). After reti_i, line 3 is serviced (vector 16'h004C) with no further edge on irq_i.
- Masking:
  - Stimulus: mask = 4'b0000, pulse irq_i[0]; then write mask = 4'b0001.
  - Required: no stall while the mask is 0. The sequence starts the cycle after the mask write, since the pending bit was retained.
- Return:
  - Stimulus: reti_i pulsed while in SERVICE with epc = 16'h0200; also pulse reti_i while in IDLE.
  - Required: pc_load_o high for one cycle with value 16'h0200, then IDLE. The reti_i pulse in IDLE produces no output change.
- Set/clear collision:
  - Stimulus: new edge on irq_i[0] in the same cycle as VECTOR for line 0.
  - Required: pending[0] remains set, and line 0 is re-serviced after RETURN.
- Reset mid-operation:
  - Stimulus: deassert rst_n during DRAIN.
  - Required: all outputs 0 immediately, asynchronously. After release, the block is in IDLE with the mask cleared and no service occurs.

Source files
------------

// File: rtl/irq_pipe_sequencer.sv
// Purpose: interrupt sequencer that drains the 5-stage pipeline, saves the return PC and vectors fetch to the ISR.
// Latency: an edge seen at cycle t is in DRAIN from t+2; the vector is loaded at t+2+DRAIN_CYC+1; RETURN follows reti_i by one cycle.
// Backpressure: none accepted; new edges are held in pending while busy and serviced in priority order after RETURN.
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   irq_i               request lines, rising-edge sensitive (index 0 = highest priority)
//   mask_we_i/_wdata_i  enable-mask write (1 = line enabled), takes effect the following cycle
//   reti_i              return-from-interrupt decoded in EX, honoured only while servicing
//   pc_if_i             PC of the next instruction to fetch, captured as the return PC
//   stall_if_o          freeze fetch while the pipeline drains and the return PC is captured
//   flush_id_o          inject EMPTY opcode into ID/EX
//   pc_load_o/_val_o    force PC to pc_load_val_o next cycle (vector or return PC)
//   epc_o               saved return PC
//   in_isr_o            ISR active (SERVICE and RETURN)
//   irq_id_o            index of the line being serviced
module irq_pipe_sequencer #(
    parameter int              N_IRQ     = 4,
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] VEC_BASE  = 'h0040,
    parameter int              DRAIN_CYC = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_IRQ-1:0]         irq_i,
    input  logic                     mask_we_i,
    input  logic [N_IRQ-1:0]         mask_wdata_i,
    input  logic                     reti_i,
    input  logic [PC_W-1:0]          pc_if_i,
    output logic                     stall_if_o,
    output logic                     flush_id_o,
    output logic                     pc_load_o,
    output logic [PC_W-1:0]          pc_load_val_o,
    output logic [PC_W-1:0]          epc_o,
    output logic                     in_isr_o,
    output logic [$clog2(N_IRQ)-1:0] irq_id_o
);

    localparam int ID_W  = $clog2(N_IRQ);
    localparam int CNT_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        SAVE    = 3'd2,
        VECTOR  = 3'd3,
        SERVICE = 3'd4,
        RETURN  = 3'd5
    } state_t;

    state_t            state, state_d;
    logic [N_IRQ-1:0]  irq_q;
    logic [N_IRQ-1:0]  pending, pending_d;
    logic [N_IRQ-1:0]  mask;
    logic [N_IRQ-1:0]  eligible;
    logic [N_IRQ-1:0]  rise;
    logic [N_IRQ-1:0]  clr_mask;
    logic [CNT_W-1:0]  drain_cnt, drain_cnt_d;
    logic [ID_W-1:0]   sel_id, sel_id_d;
    logic [ID_W-1:0]   sel_win;
    logic              clr_pend;
    logic [PC_W-1:0]   epc;
    logic [ID_W-1:0]   irq_id;
    logic [PC_W-1:0]   vec_addr;

    // ------------------------------------------------------------------
    // Edge detection and pending bookkeeping
    // ------------------------------------------------------------------
    assign rise     = irq_i & ~irq_q;
    assign clr_mask = clr_pend ? (N_IRQ'(1) << sel_id) : '0;

    // A fresh edge on the line being cleared must survive, so the set term
    // is OR-ed in after the clear.
    assign pending_d = (pending & ~clr_mask) | rise;

    // Selection uses the registered mask, so a mask write only affects
    // arbitration from the following cycle.
    assign eligible = pending & mask;

    // Lowest set index wins: scan from the top so lower indices overwrite.
    always_comb begin
        sel_win = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                sel_win = ID_W'(k);
            end
        end
    end

    // Vector slots are 4 bytes apart; the sum wraps at PC_W bits.
    assign vec_addr = VEC_BASE + (PC_W'(sel_id) << 2);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            irq_q     <= '0;
            pending   <= '0;
            mask      <= '0;
            drain_cnt <= '0;
            sel_id    <= '0;
            epc       <= '0;
            irq_id    <= '0;
        end else begin
            state     <= state_d;
            irq_q     <= irq_i;
            pending   <= pending_d;
            drain_cnt <= drain_cnt_d;
            sel_id    <= sel_id_d;
            if (mask_we_i) begin
                mask <= mask_wdata_i;
            end
            // Fetch is frozen in SAVE, so pc_if_i is the first instruction
            // that never issued: that is where the ISR must return.
            if (state == SAVE) begin
                epc <= pc_if_i;
            end
            if (state == VECTOR) begin
                irq_id <= sel_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state;
        drain_cnt_d   = drain_cnt;
        sel_id_d      = sel_id;
        clr_pend      = 1'b0;
        stall_if_o    = 1'b0;
        flush_id_o    = 1'b0;
        pc_load_o     = 1'b0;
        pc_load_val_o = '0;
        in_isr_o      = 1'b0;

        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_d     = DRAIN;
                    sel_id_d    = sel_win;
                    // Counter reaches zero on the last DRAIN cycle.
                    drain_cnt_d = CNT_W'(DRAIN_CYC - 1);
                end
            end
            DRAIN: begin
                stall_if_o = 1'b1;
                flush_id_o = 1'b1;
                if (drain_cnt == '0) begin
                    state_d = SAVE;
                end else begin
                    drain_cnt_d = drain_cnt - 1'b1;
                end
            end
            SAVE: begin
                stall_if_o = 1'b1;
                flush_id_o = 1'b1;
                state_d    = VECTOR;
            end
            VECTOR: begin
                pc_load_o     = 1'b1;
                pc_load_val_o = vec_addr;
                flush_id_o    = 1'b1;
                clr_pend      = 1'b1;
                state_d       = SERVICE;
            end
            SERVICE: begin
                in_isr_o = 1'b1;
                if (reti_i) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                // Still inside the ISR until IDLE is re-entered.
                in_isr_o      = 1'b1;
                pc_load_o     = 1'b1;
                pc_load_val_o = epc;
                flush_id_o    = 1'b1;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign epc_o    = epc;
    assign irq_id_o = irq_id;

endmodule

// File: tb/tb_irq_pipe_sequencer.sv
// Purpose: directed bench for irq_pipe_sequencer with a pc_load scoreboard and run-length monitor.
// Latency: stimulus at posedge+1, monitor samples at negedge.
// Backpressure: n/a; every wait on the DUT is bounded.
module tb_irq_pipe_sequencer;

    localparam int DRAIN_CYC = 3;

    logic        clk;
    logic        rst_n;
    logic [3:0]  irq_i;
    logic        mask_we_i;
    logic [3:0]  mask_wdata_i;
    logic        reti_i;
    logic [15:0] pc_if_i;
    logic        stall_if_o;
    logic        flush_id_o;
    logic        pc_load_o;
    logic [15:0] pc_load_val_o;
    logic [15:0] epc_o;
    logic        in_isr_o;
    logic [1:0]  irq_id_o;

    irq_pipe_sequencer #(
        .N_IRQ     (4),
        .PC_W      (16),
        .VEC_BASE  (16'h0040),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irq_i         (irq_i),
        .mask_we_i     (mask_we_i),
        .mask_wdata_i  (mask_wdata_i),
        .reti_i        (reti_i),
        .pc_if_i       (pc_if_i),
        .stall_if_o    (stall_if_o),
        .flush_id_o    (flush_id_o),
        .pc_load_o     (pc_load_o),
        .pc_load_val_o (pc_load_val_o),
        .epc_o         (epc_o),
        .in_isr_o      (in_isr_o),
        .irq_id_o      (irq_id_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_vec;
        logic [15:0] val;
        logic [15:0] epc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   stall_run = 0;
    int   flush_run = 0;
    bit   saw_stall = 0;

    logic [37:0] all_outs;
    assign all_outs = {stall_if_o, flush_id_o, pc_load_o, pc_load_val_o, epc_o, in_isr_o, irq_id_o};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every PC load must match the next expected entry;
    // stall/flush run lengths are checked when each run ends.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_run = 0;
            flush_run = 0;
            saw_stall = 0;
        end else begin
            if (pc_load_o) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pc_load: got load of 0x%0h, required no load", pc_load_val_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk(mon_e.is_vec ? "vector_pc" : "return_pc", 64'(pc_load_val_o), 64'(mon_e.val));
                    if (mon_e.is_vec) chk("epc_at_vector", 64'(epc_o), 64'(mon_e.epc));
                end
            end
            if (stall_if_o) begin
                stall_run++;
            end else if (stall_run > 0) begin
                chk("stall_len", 64'(stall_run), 64'(DRAIN_CYC + 1));
                stall_run = 0;
            end
            if (flush_id_o) begin
                flush_run++;
                if (stall_if_o) saw_stall = 1;
            end else if (flush_run > 0) begin
                chk(saw_stall ? "flush_len_entry" : "flush_len_return",
                    64'(flush_run), saw_stall ? 64'(DRAIN_CYC + 2) : 64'd1);
                flush_run = 0;
                saw_stall = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic is_vec, input logic [15:0] val, input logic [15:0] epc);
        exp_t t;
        t.is_vec = is_vec;
        t.val    = val;
        t.epc    = epc;
        exp_q.push_back(t);
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_wdata_i = m;
        mask_we_i    = 1'b1;
        tick();
        mask_we_i    = 1'b0;
    endtask

    task automatic pulse_irq(input logic [3:0] m);
        irq_i = m;
        tick();
        irq_i = 4'b0000;
    endtask

    task automatic wait_isr(input string name);
        int k = 0;
        while (!in_isr_o && k < 30) begin
            tick();
            k++;
        end
        chk(name, 64'(in_isr_o), 64'd1);
    endtask

    // Pulse reti in SERVICE: RETURN loads the saved PC, then IDLE.
    task automatic do_reti(input logic [15:0] ret_pc);
        push_exp(1'b0, ret_pc, 16'h0000);
        reti_i = 1'b1;
        tick();
        reti_i = 1'b0;
        chk("ret_pc_load", 64'(pc_load_o), 64'd1);
        chk("ret_in_isr", 64'(in_isr_o), 64'd1);
        tick();
        chk("ret_idle_pc_load", 64'(pc_load_o), 64'd0);
        chk("ret_idle_in_isr", 64'(in_isr_o), 64'd0);
    endtask

    task automatic quiet_window(input string name, input int n);
        int act = 0;
        repeat (n) begin
            tick();
            if (stall_if_o || flush_id_o || pc_load_o || in_isr_o) act++;
        end
        chk(name, 64'(act), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_n = 1'b0; irq_i = '0; mask_we_i = 1'b0; mask_wdata_i = '0;
        reti_i = 1'b0; pc_if_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("outs_in_reset", 64'(all_outs), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("outs_after_reset", 64'(all_outs), 64'd0);

        // Basic entry on line 2
        pc_if_i = 16'h0100;
        write_mask(4'b1111);
        push_exp(1'b1, 16'h0048, 16'h0100);
        pulse_irq(4'b0100);
        chk("basic_idle_no_stall", 64'(stall_if_o), 64'd0);
        for (int i = 0; i < DRAIN_CYC + 1; i++) begin
            tick();
            chk("basic_stall", 64'(stall_if_o), 64'd1);
        end
        tick();
        chk("basic_vector_load", 64'(pc_load_o), 64'd1);
        chk("basic_vector_stall", 64'(stall_if_o), 64'd0);
        tick();
        chk("basic_in_isr", 64'(in_isr_o), 64'd1);
        chk("basic_irq_id", 64'(irq_id_o), 64'd2);
        chk("basic_epc", 64'(epc_o), 64'h0100);
        tick();
        do_reti(16'h0100);

        // Priority: lines 3 and 1 together, 1 first, 3 without a new edge
        pc_if_i = 16'h0300;
        push_exp(1'b1, 16'h0044, 16'h0300);
        pulse_irq(4'b1010);
        wait_isr("prio_first_isr");
        chk("prio_first_id", 64'(irq_id_o), 64'd1);
        do_reti(16'h0300);
        push_exp(1'b1, 16'h004C, 16'h0300);
        tick();
        chk("prio_redrain_r3", 64'(stall_if_o), 64'd1);
        wait_isr("prio_second_isr");
        chk("prio_second_id", 64'(irq_id_o), 64'd3);
        do_reti(16'h0300);

        // Masking: pending retained while disabled
        pc_if_i = 16'h0400;
        write_mask(4'b0000);
        pulse_irq(4'b0001);
        quiet_window("mask_zero_quiet", 10);
        push_exp(1'b1, 16'h0040, 16'h0400);
        write_mask(4'b0001);
        chk("mask_write_cycle_idle", 64'(stall_if_o), 64'd0);
        tick();
        chk("mask_enable_drain", 64'(stall_if_o), 64'd1);
        wait_isr("mask_isr");
        chk("mask_irq_id", 64'(irq_id_o), 64'd0);
        do_reti(16'h0400);

        // Return: reti in IDLE is ignored, then a real return to 0x0200
        reti_i = 1'b1;
        tick();
        reti_i = 1'b0;
        chk("reti_idle_outs", 64'(all_outs), {26'd0, 16'h0400, 1'b0, 2'd0});
        tick();
        chk("reti_idle_outs_next", 64'(all_outs), {26'd0, 16'h0400, 1'b0, 2'd0});
        pc_if_i = 16'h0200;
        push_exp(1'b1, 16'h0040, 16'h0200);
        pulse_irq(4'b0001);
        wait_isr("ret_isr");
        chk("ret_epc", 64'(epc_o), 64'h0200);
        do_reti(16'h0200);

        // Set/clear collision on line 0 during VECTOR
        pc_if_i = 16'h0500;
        push_exp(1'b1, 16'h0040, 16'h0500);
        pulse_irq(4'b0001);
        k = 0;
        while (!pc_load_o && k < 30) begin
            tick();
            k++;
        end
        chk("coll_vector_seen", 64'(pc_load_o), 64'd1);
        pulse_irq(4'b0001);
        chk("coll_in_isr", 64'(in_isr_o), 64'd1);
        tick();
        do_reti(16'h0500);
        push_exp(1'b1, 16'h0040, 16'h0500);
        wait_isr("coll_reservice");
        chk("coll_irq_id", 64'(irq_id_o), 64'd0);
        do_reti(16'h0500);
        quiet_window("coll_cleared_quiet", 8);

        // Reset mid-DRAIN
        write_mask(4'b1111);
        pulse_irq(4'b0010);
        tick();
        chk("rst_in_drain", 64'(stall_if_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_outs", 64'(all_outs), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        quiet_window("rst_release_quiet", 8);
        pulse_irq(4'b0100);
        quiet_window("rst_mask_cleared", 8);
        write_mask(4'b0010);
        quiet_window("rst_pending_cleared", 8);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
